// File: rtl/phys_reg_freelist_pkg.sv
// Shared parameters and types for the physical register free list.
// Architectural registers 0..ARCH_REGS-1 start out identity-mapped.
package phys_reg_freelist_pkg;

    localparam int DISPATCH_WIDTH       = 2;
    localparam int ARCH_REGS            = 32;
    localparam int PHYS_REGS            = 64;
    localparam int PHYS_REGS_ADDR_WIDTH = 6;
    localparam int FL_DEPTH             = PHYS_REGS - ARCH_REGS;
    localparam int FL_IDX_WIDTH         = $clog2(FL_DEPTH);
    localparam int FL_PTR_WIDTH         = FL_IDX_WIDTH + 1;
    localparam int CNT_WIDTH            = $clog2(DISPATCH_WIDTH + 1);

    typedef logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_reg_t;
    typedef logic [FL_PTR_WIDTH-1:0]         fl_ptr_t;
    typedef logic [FL_IDX_WIDTH-1:0]         fl_idx_t;
    typedef logic [CNT_WIDTH-1:0]            slot_cnt_t;

endpackage

// File: rtl/phys_reg_freelist_prefix_popcount.sv
// Exclusive prefix count: prefix_o[i] = number of set bits below slot i.
// total_o is the full population count.
module prefix_popcount #(
    parameter int WIDTH = 2,
    parameter int CW    = 2
) (
    input  logic [0:WIDTH-1] bits_i,
    output logic [CW-1:0]    prefix_o [WIDTH],
    output logic [CW-1:0]    total_o
);

    always_comb begin
        logic [CW-1:0] acc;
        acc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            prefix_o[i] = acc;
            acc = acc + CW'(bits_i[i]);
        end
        total_o = acc;
    end

endmodule

// File: rtl/phys_reg_freelist.sv
// Circular free list of physical registers: all-or-nothing rename
// allocation, commit-side reclaim, sticky overflow detection.
module phys_reg_freelist
    import phys_reg_freelist_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [0:DISPATCH_WIDTH-1] alloc_req,
    output phys_reg_t                 alloc_phys_rd [DISPATCH_WIDTH],
    output logic                      alloc_grant,
    output logic                      alloc_stall,
    input  logic [0:DISPATCH_WIDTH-1] free_en,
    input  phys_reg_t                 free_phys_rd [DISPATCH_WIDTH],
    output logic [FL_PTR_WIDTH-1:0]   free_count,
    output logic                      overflow_err
);

    phys_reg_t entry_q [FL_DEPTH];
    fl_ptr_t   head_q, head_d;
    fl_ptr_t   tail_q, tail_d;
    logic      ovf_q, ovf_d;

    logic [0:DISPATCH_WIDTH-1] push_ok;
    slot_cnt_t a_pfx [DISPATCH_WIDTH];
    slot_cnt_t f_pfx [DISPATCH_WIDTH];
    slot_cnt_t a_tot, f_tot;
    fl_ptr_t   room, n_push;
    logic      fits;

    always_comb begin
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            push_ok[i] = free_en[i] && (free_phys_rd[i] != '0);
        end
    end

    prefix_popcount #(
        .WIDTH (DISPATCH_WIDTH),
        .CW    (CNT_WIDTH)
    ) u_alloc_cnt (
        .bits_i   (alloc_req),
        .prefix_o (a_pfx),
        .total_o  (a_tot)
    );

    prefix_popcount #(
        .WIDTH (DISPATCH_WIDTH),
        .CW    (CNT_WIDTH)
    ) u_free_cnt (
        .bits_i   (push_ok),
        .prefix_o (f_pfx),
        .total_o  (f_tot)
    );

    assign free_count   = tail_q - head_q;
    assign overflow_err = ovf_q;
    assign fits         = fl_ptr_t'(a_tot) <= free_count;

    always_comb begin
        alloc_grant = !rst && (a_tot != '0) && fits;
        alloc_stall = !rst && (a_tot != '0) && !fits;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            alloc_phys_rd[i] = '0;
            if (!rst && alloc_req[i]) begin
                alloc_phys_rd[i] =
                    entry_q[fl_idx_t'(head_q + fl_ptr_t'(a_pfx[i]))];
            end
        end
    end

    // Room is measured after this cycle's pop; pushes beyond it are dropped.
    always_comb begin
        head_d = head_q;
        if (alloc_grant) begin
            head_d = head_q + fl_ptr_t'(a_tot);
        end
        room   = fl_ptr_t'(FL_DEPTH) - (tail_q - head_d);
        n_push = fl_ptr_t'(f_tot);
        ovf_d  = ovf_q;
        if (fl_ptr_t'(f_tot) > room) begin
            n_push = room;
            ovf_d  = 1'b1;
        end
        tail_d = tail_q + n_push;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= fl_ptr_t'(FL_DEPTH);
            ovf_q  <= 1'b0;
            for (int k = 0; k < FL_DEPTH; k++) begin
                entry_q[k] <= phys_reg_t'(ARCH_REGS + k);
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            ovf_q  <= ovf_d;
            for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                if (push_ok[i] && (fl_ptr_t'(f_pfx[i]) < room)) begin
                    entry_q[fl_idx_t'(tail_q + fl_ptr_t'(f_pfx[i]))]
                        <= free_phys_rd[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_phys_reg_freelist.sv
// Scoreboard bench for phys_reg_freelist: a FIFO reference of free
// registers predicts each allocation response checked by a monitor.
module tb_phys_reg_freelist;
    import phys_reg_freelist_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:1] alloc_req;
    phys_reg_t  alloc_phys_rd [2];
    logic       alloc_grant;
    logic       alloc_stall;
    logic [0:1] free_en;
    phys_reg_t  free_phys_rd [2];
    logic [FL_PTR_WIDTH-1:0] free_count;
    logic       overflow_err;

    phys_reg_freelist dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_req     (alloc_req),
        .alloc_phys_rd (alloc_phys_rd),
        .alloc_grant   (alloc_grant),
        .alloc_stall   (alloc_stall),
        .free_en       (free_en),
        .free_phys_rd  (free_phys_rd),
        .free_count    (free_count),
        .overflow_err  (overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       g;
        logic       s;
        logic [0:1] req;
        int         rd [2];
        int         cnt;
        logic       ovf;
    } exp_t;

    exp_t sb [$];
    int   mq [$];
    logic movf;
    int   total = 0;
    int   bad   = 0;

    function automatic void check(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (alloc_grant || alloc_stall) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("grant", int'(alloc_grant), int'(e.g));
                check("stall", int'(alloc_stall), int'(e.s));
                for (int i = 0; i < 2; i++) begin
                    if (e.g || !e.req[i]) begin
                        check($sformatf("rd%0d", i),
                              int'(alloc_phys_rd[i]), e.rd[i]);
                    end
                end
                check("resp_count", int'(free_count), e.cnt);
                check("resp_ovf", int'(overflow_err), int'(e.ovf));
            end
        end
    end

    task automatic model_reset();
        mq.delete();
        for (int k = 0; k < 32; k++) mq.push_back(32 + k);
        movf = 1'b0;
    endtask

    task automatic cyc(input logic [0:1] req, input logic [0:1] fe,
                       input int f0, input int f1);
        exp_t e;
        int n;
        int pos;
        int fr [2];
        fr[0] = f0;
        fr[1] = f1;
        n = int'(req[0]) + int'(req[1]);
        e.req = req;
        e.cnt = mq.size();
        e.ovf = movf;
        e.g = (n > 0) && (n <= mq.size());
        e.s = (n > 0) && !e.g;
        pos = 0;
        for (int i = 0; i < 2; i++) begin
            e.rd[i] = 0;
            if (req[i]) begin
                if (e.g) e.rd[i] = mq[pos];
                pos++;
            end
        end
        if (n > 0) sb.push_back(e);
        alloc_req = req;
        free_en = fe;
        free_phys_rd[0] = phys_reg_t'(f0);
        free_phys_rd[1] = phys_reg_t'(f1);
        @(posedge clk);
        #1;
        if (e.g) begin
            for (int i = 0; i < n; i++) void'(mq.pop_front());
        end
        for (int i = 0; i < 2; i++) begin
            if (fe[i] && fr[i] != 0) begin
                if (mq.size() < 32) mq.push_back(fr[i]);
                else movf = 1'b1;
            end
        end
        alloc_req = '0;
        free_en = '0;
    endtask

    // Reset is asserted with live requests to prove they are ignored.
    task automatic do_reset();
        rst = 1'b1;
        alloc_req = 2'b11;
        free_en = 2'b11;
        free_phys_rd[0] = 6'd1;
        free_phys_rd[1] = 6'd2;
        @(negedge clk);
        check("rst_grant", int'(alloc_grant), 0);
        check("rst_stall", int'(alloc_stall), 0);
        check("rst_rd0", int'(alloc_phys_rd[0]), 0);
        check("rst_rd1", int'(alloc_phys_rd[1]), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        alloc_req = '0;
        free_en = '0;
        model_reset();
        check("rst_count", int'(free_count), 32);
        check("rst_ovf", int'(overflow_err), 0);
    endtask

    initial begin
        int a;
        int b;
        do_reset();
        cyc(2'b11, 2'b00, 0, 0);
        check("count_after_pair", int'(free_count), 30);

        do_reset();
        cyc(2'b01, 2'b00, 0, 0);
        check("count_after_slot1", int'(free_count), 31);

        do_reset();
        for (int i = 0; i < 16; i++) cyc(2'b11, 2'b00, 0, 0);
        check("count_empty", int'(free_count), 0);
        cyc(2'b10, 2'b00, 0, 0);
        check("count_after_stall", int'(free_count), 0);
        cyc(2'b00, 2'b10, 45, 0);
        cyc(2'b10, 2'b00, 0, 0);

        do_reset();
        for (int i = 0; i < 15; i++) cyc(2'b11, 2'b00, 0, 0);
        cyc(2'b10, 2'b00, 0, 0);
        check("count_one", int'(free_count), 1);
        cyc(2'b11, 2'b10, 40, 0);
        check("count_no_bypass", int'(free_count), 2);
        cyc(2'b11, 2'b00, 0, 0);
        check("count_drained", int'(free_count), 0);

        do_reset();
        for (int i = 0; i < 50; i++) begin
            a = mq[0];
            b = mq[1];
            cyc(2'b11, 2'b00, 0, 0);
            cyc(2'b00, 2'b11, a, b);
        end
        check("count_wrap", int'(free_count), 32);

        cyc(2'b00, 2'b11, 5, 6);
        check("ovf_set", int'(overflow_err), 1);
        check("count_ovf", int'(free_count), 32);
        cyc(2'b10, 2'b00, 0, 0);
        cyc(2'b00, 2'b11, 0, 7);
        check("count_x0_drop", int'(free_count), 32);
        cyc(2'b01, 2'b00, 0, 0);
        cyc(2'b00, 2'b11, 8, 9);
        check("count_partial", int'(free_count), 32);
        check("ovf_sticky", int'(overflow_err), 1);
        for (int i = 0; i < 16; i++) cyc(2'b11, 2'b00, 0, 0);
        check("count_final_drain", int'(free_count), 0);

        do_reset();
        cyc(2'b11, 2'b00, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
